// File: rtl/cdec_bus_pkg.sv
// cdec_bus_pkg: shared state, owner and op encodings for the CDEC memory responder
package cdec_bus_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
   typedef enum logic {OWN_CPU, OWN_MON} owner_t;
   typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/cdec_ram_sp.sv
// cdec_ram_sp: single-port RAM with synchronous write and registered read
module cdec_ram_sp #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
   end
   assign rdata = rdata_q;
endmodule

// File: rtl/cdec_mem_responder.sv
// cdec_mem_responder: arbitrates CPU and monitor requests onto the program/data RAM
module cdec_mem_responder
   import cdec_bus_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              cpu_halted,
   input  logic [ADDR_W-1:0] mon_addr,
   input  logic [DATA_W-1:0] mon_wdata,
   input  logic              mon_rd,
   input  logic              mon_wr,
   output logic [DATA_W-1:0] mon_rdata,
   output logic              mon_ack,
   output logic              busy
);
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
   localparam state_t FIRST_ST = WAIT_CYCLES == 0 ? ACCESS : WAIT;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   op_t               op_q, op_d;
   logic [2:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, mon_rdata_q, mon_rdata_d;
   logic              cpu_ack_q, cpu_ack_d, mon_ack_q, mon_ack_d, busy_q, busy_d;
   logic              cpu_req, mon_go;
   logic [DATA_W-1:0] ram_rdata, resp_data;

   assign cpu_req = cpu_rd | cpu_wr;
   // a monitor write is held off (no ack) until the CPU has halted
   assign mon_go = mon_wr ? cpu_halted : mon_rd;
   assign resp_data = op_q == OP_WR ? wdata_q : ram_rdata;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      op_d        = op_q;
      wait_d      = wait_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      mon_rdata_d = mon_rdata_q;
      cpu_ack_d   = 1'b0;
      mon_ack_d   = 1'b0;
      case (state_q)
         IDLE: if (cpu_req || mon_go) begin
            owner_d = cpu_req ? OWN_CPU : OWN_MON;
            op_d    = (cpu_req ? cpu_wr : mon_wr) ? OP_WR : OP_RD;
            addr_d  = cpu_req ? cpu_addr : mon_addr;
            wdata_d = cpu_req ? cpu_wdata : mon_wdata;
            wait_d  = WAIT_INIT;
            state_d = FIRST_ST;
         end
         WAIT: begin
            wait_d  = wait_q - 3'd1;
            state_d = wait_q == 3'd0 ? ACCESS : WAIT;
         end
         ACCESS: begin
            cpu_ack_d   = owner_q == OWN_CPU;
            mon_ack_d   = owner_q == OWN_MON;
            cpu_rdata_d = owner_q == OWN_CPU ? resp_data : cpu_rdata_q;
            mon_rdata_d = owner_q == OWN_MON ? resp_data : mon_rdata_q;
            state_d     = RESP;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= OWN_CPU;
         op_q        <= OP_RD;
         wait_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         mon_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         mon_ack_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         op_q        <= op_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         mon_rdata_q <= mon_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         mon_ack_q   <= mon_ack_d;
         busy_q      <= busy_d;
      end
   end

   // RAM follows the next address so its registered output is current by ACCESS
   cdec_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .we    (state_q == ACCESS && op_q == OP_WR && !reset),
      .addr  (addr_d),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign cpu_rdata = cpu_rdata_q;
   assign mon_rdata = mon_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign mon_ack   = mon_ack_q;
   assign busy      = busy_q;
endmodule
